// File: rtl/bias_ram_ctrl.sv
// Bias-RAM responder: packs 64-bit DMA beats into 512-bit lines in a simple
// dual-port RAM and serves 1-cycle-latency reads to the bias stage.
module bias_ram_ctrl #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int WR_DATA_WIDTH  = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_load_start,
    input  logic [RAM_ADDR_WIDTH-1:0] i_load_base,
    input  logic [RAM_ADDR_WIDTH:0]   i_load_lines,
    input  logic [WR_DATA_WIDTH-1:0]  i_wr_dat,
    input  logic                      i_wr_vld,
    output logic                      o_wr_rdy,
    output logic                      o_load_busy,
    output logic                      o_load_done,
    input  logic                      i_ram_rd_en,
    input  logic [RAM_ADDR_WIDTH-1:0] i_ram_addr,
    output logic [511:0]              o_ram_dat,
    output logic                      o_ram_dat_vld,
    output logic                      o_rd_err
);

    localparam int LINE_W  = 512;
    localparam int BEATS   = LINE_W / WR_DATA_WIDTH;
    localparam int STAGE_W = LINE_W - WR_DATA_WIDTH;
    localparam int DEPTH   = 1 << RAM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                beat_q, beat_d;
    logic [RAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [RAM_ADDR_WIDTH:0]   left_q, left_d;
    logic [STAGE_W-1:0]        staging_q, staging_d;
    logic                      wr_rdy_q, wr_rdy_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [LINE_W-1:0]         rd_dat_q, rd_dat_d;
    logic                      rd_vld_q, rd_vld_d;
    logic                      rd_err_q, rd_err_d;
    logic                      ram_we_s;
    logic [LINE_W-1:0]         ram_wdat_s;
    logic [LINE_W-1:0]         ram_q [DEPTH];

    // Load FSM, beat packing and read-path next-state logic.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        ptr_d      = ptr_q;
        left_d     = left_q;
        staging_d  = staging_q;
        ram_we_s   = 1'b0;
        ram_wdat_s = {i_wr_dat, staging_q};

        case (state_q)
            ST_IDLE: begin
                if (i_load_start) begin
                    ptr_d   = i_load_base;
                    left_d  = i_load_lines;
                    beat_d  = 3'd0;
                    if (i_load_lines != {(RAM_ADDR_WIDTH+1){1'b0}}) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (i_wr_vld) begin
                    if (beat_q == 3'(BEATS - 1)) begin
                        ram_we_s = 1'b1;
                        ptr_d    = ptr_q + RAM_ADDR_WIDTH'(1);
                        left_d   = left_q - (RAM_ADDR_WIDTH+1)'(1);
                        beat_d   = 3'd0;
                        if (left_q == (RAM_ADDR_WIDTH+1)'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        for (int k = 0; k < BEATS - 1; k++) begin
                            if (beat_q == 3'(k)) begin
                                staging_d[k*WR_DATA_WIDTH +: WR_DATA_WIDTH] = i_wr_dat;
                            end else begin
                                staging_d[k*WR_DATA_WIDTH +: WR_DATA_WIDTH] =
                                    staging_q[k*WR_DATA_WIDTH +: WR_DATA_WIDTH];
                            end
                        end
                        beat_d = beat_q + 3'd1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_rdy_d = (state_d == ST_LOAD);
        busy_d   = (state_d == ST_LOAD);
        done_d   = (state_d == ST_DONE);

        // Read-first: the array read sees the contents before this edge's write.
        if (i_ram_rd_en) begin
            rd_dat_d = ram_q[i_ram_addr];
        end else begin
            rd_dat_d = rd_dat_q;
        end
        rd_vld_d = i_ram_rd_en;
        rd_err_d = i_ram_rd_en && (state_q == ST_LOAD);
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= 3'd0;
            ptr_q     <= {RAM_ADDR_WIDTH{1'b0}};
            left_q    <= {(RAM_ADDR_WIDTH+1){1'b0}};
            staging_q <= {STAGE_W{1'b0}};
            wr_rdy_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_dat_q  <= {LINE_W{1'b0}};
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            ptr_q     <= ptr_d;
            left_q    <= left_d;
            staging_q <= staging_d;
            wr_rdy_q  <= wr_rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_dat_q  <= rd_dat_d;
            rd_vld_q  <= rd_vld_d;
            rd_err_q  <= rd_err_d;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (ram_we_s && i_rst_n) begin
            ram_q[ptr_q] <= ram_wdat_s;
        end
    end

    assign o_wr_rdy      = wr_rdy_q;
    assign o_load_busy   = busy_q;
    assign o_load_done   = done_q;
    assign o_ram_dat     = rd_dat_q;
    assign o_ram_dat_vld = rd_vld_q;
    assign o_rd_err      = rd_err_q;

endmodule

// File: tb/tb_bias_ram_ctrl.sv
// Directed self-checking bench for bias_ram_ctrl.
module tb_bias_ram_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_start;
    logic [7:0]   load_base;
    logic [8:0]   load_lines;
    logic [63:0]  wr_dat;
    logic         wr_vld;
    logic         wr_rdy;
    logic         load_busy;
    logic         load_done;
    logic         rd_en;
    logic [7:0]   rd_addr;
    logic [511:0] rd_dat;
    logic         rd_vld;
    logic         rd_err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bias_ram_ctrl #(.RAM_ADDR_WIDTH(8), .WR_DATA_WIDTH(64)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_load_start  (load_start),
        .i_load_base   (load_base),
        .i_load_lines  (load_lines),
        .i_wr_dat      (wr_dat),
        .i_wr_vld      (wr_vld),
        .o_wr_rdy      (wr_rdy),
        .o_load_busy   (load_busy),
        .o_load_done   (load_done),
        .i_ram_rd_en   (rd_en),
        .i_ram_addr    (rd_addr),
        .o_ram_dat     (rd_dat),
        .o_ram_dat_vld (rd_vld),
        .o_rd_err      (rd_err)
    );

    // Line whose beat k is byte (b0+k) replicated eight times.
    function automatic logic [511:0] make_line(input logic [7:0] b0);
        logic [511:0] l;
        logic [7:0]   b;
        for (int k = 0; k < 8; k++) begin
            b = b0 + 8'(k);
            l[k*64 +: 64] = {8{b}};
        end
        return l;
    endfunction

    function automatic logic [63:0] beat_of(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] base, input logic [8:0] lines);
        load_base  = base;
        load_lines = lines;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] b);
        wr_dat = beat_of(b);
        wr_vld = 1'b1;
        step();
        wr_vld = 1'b0;
    endtask

    task automatic read_check(input logic [7:0] addr, input logic [511:0] exp, input string name);
        rd_en   = 1'b1;
        rd_addr = addr;
        step();
        rd_en   = 1'b0;
        checks++;
        if (rd_vld !== 1'b1 || rd_dat !== exp) begin
            fails++;
            $display("FAIL %s: vld=%0b dat=%h required vld=1 dat=%h", name, rd_vld, rd_dat, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 1'b0; load_base = 8'd0; load_lines = 9'd0;
        wr_dat = 64'd0; wr_vld = 1'b1; rd_en = 1'b0; rd_addr = 8'd0;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        checks++;
        if ({wr_rdy, load_busy, load_done, rd_vld, rd_err} !== 5'b0 || rd_dat !== 512'd0) begin
            fails++;
            $display("FAIL reset_outputs: rdy/busy/done/vld/err=%b dat=%h required 00000 and 0",
                     {wr_rdy, load_busy, load_done, rd_vld, rd_err}, rd_dat);
        end else begin
            passed++;
        end
        wr_vld = 1'b0;
    endtask

    task automatic test_load_basic();
        start_load(8'h10, 9'd2);
        checks++;
        if (wr_rdy !== 1'b1 || load_busy !== 1'b1) begin
            fails++;
            $display("FAIL load_start: rdy=%0b busy=%0b required 1 1", wr_rdy, load_busy);
        end else begin
            passed++;
        end
        for (int i = 0; i < 16; i++) begin
            send_beat(8'(i));
        end
        checks++;
        if (load_done !== 1'b1 || load_busy !== 1'b0 || wr_rdy !== 1'b0) begin
            fails++;
            $display("FAIL load_done_pulse: done=%0b busy=%0b rdy=%0b required 1 0 0",
                     load_done, load_busy, wr_rdy);
        end else begin
            passed++;
        end
        step();
        checks++;
        if (load_done !== 1'b0) begin
            fails++;
            $display("FAIL load_done_width: done=%0b required 0", load_done);
        end else begin
            passed++;
        end
        read_check(8'h10, make_line(8'h00), "read_line_10");
        read_check(8'h11, make_line(8'h08), "read_line_11");
        step();
        checks++;
        if (rd_vld !== 1'b0 || rd_dat !== make_line(8'h08)) begin
            fails++;
            $display("FAIL read_hold: vld=%0b dat=%h required vld=0 dat=%h", rd_vld, rd_dat, make_line(8'h08));
        end else begin
            passed++;
        end
    endtask

    task automatic test_wrap_stall();
        start_load(8'hFF, 9'd2);
        for (int i = 0; i < 16; i++) begin
            if (i != 0) begin
                wr_dat = 64'hDEAD_BEEF_DEAD_BEEF;
                wr_vld = 1'b0;
                step();
            end
            send_beat(8'hA0 + 8'(i));
        end
        checks++;
        if (load_done !== 1'b1) begin
            fails++;
            $display("FAIL wrap_done: done=%0b required 1", load_done);
        end else begin
            passed++;
        end
        step();
        read_check(8'hFF, make_line(8'hA0), "wrap_line_ff");
        read_check(8'h00, make_line(8'hA8), "wrap_line_00");
        read_check(8'h10, make_line(8'h00), "wrap_untouched_10");
    endtask

    task automatic test_zero_lines();
        start_load(8'h10, 9'd0);
        checks++;
        if (load_done !== 1'b1 || load_busy !== 1'b0 || wr_rdy !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: done=%0b busy=%0b rdy=%0b required 1 0 0", load_done, load_busy, wr_rdy);
        end else begin
            passed++;
        end
        wr_dat = beat_of(8'h77);
        wr_vld = 1'b1;
        step();
        wr_vld = 1'b0;
        checks++;
        if (load_done !== 1'b0 || load_busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_after: done=%0b busy=%0b required 0 0", load_done, load_busy);
        end else begin
            passed++;
        end
        read_check(8'h10, make_line(8'h00), "zero_no_write");
    endtask

    task automatic test_read_during_load();
        start_load(8'h10, 9'd1);
        for (int i = 0; i < 7; i++) begin
            send_beat(8'hC0 + 8'(i));
        end
        wr_dat  = beat_of(8'hC7);
        wr_vld  = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 8'h10;
        step();
        wr_vld  = 1'b0;
        rd_en   = 1'b0;
        checks++;
        if (rd_dat !== make_line(8'h00) || rd_vld !== 1'b1 || rd_err !== 1'b1) begin
            fails++;
            $display("FAIL rdw_old_line: dat=%h vld=%0b err=%0b required dat=%h vld=1 err=1",
                     rd_dat, rd_vld, rd_err, make_line(8'h00));
        end else begin
            passed++;
        end
        read_check(8'h10, make_line(8'hC0), "rdw_new_line");
        checks++;
        if (rd_err !== 1'b0) begin
            fails++;
            $display("FAIL rdw_no_err_outside_load: err=%0b required 0", rd_err);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset_mid_load();
        start_load(8'h21, 9'd1);
        for (int i = 0; i < 8; i++) begin
            send_beat(8'h50 + 8'(i));
        end
        step();
        start_load(8'h20, 9'd2);
        for (int i = 0; i < 11; i++) begin
            send_beat(8'hE0 + 8'(i));
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({wr_rdy, load_busy, load_done, rd_vld, rd_err} !== 5'b0 || rd_dat !== 512'd0) begin
            fails++;
            $display("FAIL midreset_state: rdy/busy/done/vld/err=%b dat=%h required 00000 and 0",
                     {wr_rdy, load_busy, load_done, rd_vld, rd_err}, rd_dat);
        end else begin
            passed++;
        end
        wr_dat = beat_of(8'h99);
        wr_vld = 1'b1;
        step();
        wr_vld = 1'b0;
        checks++;
        if (wr_rdy !== 1'b0 || load_busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle: rdy=%0b busy=%0b required 0 0", wr_rdy, load_busy);
        end else begin
            passed++;
        end
        read_check(8'h20, make_line(8'hE0), "midreset_line0");
        read_check(8'h21, make_line(8'h50), "midreset_line1_kept");
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_wrap_stall();
        test_zero_lines();
        test_read_during_load();
        test_reset_mid_load();
        if (passed + fails != checks) begin
            fails++;
            $display("FAIL bookkeeping: passed=%0d fails=%0d checks=%0d", passed, fails, checks);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
